// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard/forwarding unit: EX operand-mux select
// encodings and a register one-hot helper.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        NO_FWD  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_ACC = 2'b11
    } fwd_sel_e;

    function automatic logic [31:0] onehot32(input logic [4:0] r);
        onehot32 = 32'd1 << r;
    endfunction

endpackage

// File: rtl/acc_scoreboard.sv
// Tracks accelerator destination registers in flight, the outstanding-op
// count and a sticky flag for write-backs that match no pending register.
module acc_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [4:0]       issue_rd,
    input  logic             acc_wb_valid,
    input  logic [4:0]       acc_wb_rd,
    output logic [31:0]      pending,
    output logic [31:0]      eff_pending,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_spurious
);

    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [31:0]      clearing;
    logic             wb_hit;

    always_comb begin
        clearing    = acc_wb_valid ? onehot32(acc_wb_rd) : '0;
        eff_pending = pending_q & ~clearing;
        wb_hit      = acc_wb_valid && (acc_wb_rd != '0) && pending_q[acc_wb_rd];
        // Set is applied after clear so a same-cycle reissue keeps the bit.
        pending_d   = eff_pending | (issue ? onehot32(issue_rd) : '0);
        count_d     = count_q;
        if (issue && !wb_hit)
            count_d = count_q + CNT_W'(1);
        else if (!issue && wb_hit && (count_q != '0))
            count_d = count_q - CNT_W'(1);
        err_d       = err_q | (acc_wb_valid && !wb_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign pending      = pending_q;
    assign outstanding  = count_q;
    assign err_spurious = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// EX-stage forwarding for NUM_SRC operands plus ID-stage stall generation
// (load-use, RAW/WAW on pending accelerator results, accelerator queue full).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned ACC_DEPTH = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 flush_id,
    input  logic [NUM_SRC*5-1:0] rs_id,
    input  logic [NUM_SRC-1:0]   rs_used_id,
    input  logic [4:0]           rd_id,
    input  logic                 reg_write_id,
    input  logic                 is_acc_id,
    input  logic [NUM_SRC*5-1:0] rs_ex,
    input  logic [4:0]           rd_ex,
    input  logic                 mem_read_ex,
    input  logic                 reg_write_mem,
    input  logic [4:0]           rd_mem,
    input  logic                 reg_write_wb,
    input  logic [4:0]           rd_wb,
    input  logic                 acc_wb_valid,
    input  logic [4:0]           acc_wb_rd,
    output logic [NUM_SRC*2-1:0] fwd_sel_ex,
    output logic                 stall_id,
    output logic [31:0]          acc_pending,
    output logic [CNT_W-1:0]     acc_outstanding,
    output logic                 err_spurious
);

    logic [31:0] eff_pending;
    logic        issue;
    logic        load_use, raw, waw, full;
    logic [4:0]  rs_k;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        logic [4:0] rs;
        fwd_sel_e   sel;
        assign rs = rs_ex[5*k +: 5];
        // Later assignments take priority: MEM over WB over accelerator.
        always_comb begin
            sel = NO_FWD;
            if (acc_wb_valid && (acc_wb_rd == rs))
                sel = FWD_ACC;
            if (reg_write_wb && (rd_wb == rs))
                sel = FWD_WB;
            if (reg_write_mem && (rd_mem == rs))
                sel = FWD_MEM;
            if (rs == '0)
                sel = NO_FWD;
        end
        assign fwd_sel_ex[2*k +: 2] = sel;
    end

    always_comb begin
        load_use = 1'b0;
        raw      = 1'b0;
        rs_k     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rs_k = rs_id[5*i +: 5];
            if (rs_used_id[i] && mem_read_ex && (rd_ex != '0) && (rs_k == rd_ex))
                load_use = 1'b1;
            if (rs_used_id[i] && (rs_k != '0) && eff_pending[rs_k])
                raw = 1'b1;
        end
        waw      = reg_write_id && (rd_id != '0) && eff_pending[rd_id];
        full     = is_acc_id && (acc_outstanding == CNT_W'(ACC_DEPTH)) && !acc_wb_valid;
        stall_id = id_valid && (load_use || raw || waw || full);
        issue    = id_valid && is_acc_id && reg_write_id && !stall_id && !flush_id
                   && (rd_id != '0);
    end

    acc_scoreboard #(
        .CNT_W(CNT_W)
    ) u_acc_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .issue_rd     (rd_id),
        .acc_wb_valid (acc_wb_valid),
        .acc_wb_rd    (acc_wb_rd),
        .pending      (acc_pending),
        .eff_pending  (eff_pending),
        .outstanding  (acc_outstanding),
        .err_spurious (err_spurious)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, flush_id;
    logic [14:0] rs_id;
    logic [2:0]  rs_used_id;
    logic [4:0]  rd_id;
    logic        reg_write_id, is_acc_id;
    logic [14:0] rs_ex;
    logic [4:0]  rd_ex;
    logic        mem_read_ex;
    logic        reg_write_mem;
    logic [4:0]  rd_mem;
    logic        reg_write_wb;
    logic [4:0]  rd_wb;
    logic        acc_wb_valid;
    logic [4:0]  acc_wb_rd;
    logic [5:0]  fwd_sel_ex;
    logic        stall_id;
    logic [31:0] acc_pending;
    logic [2:0]  acc_outstanding;
    logic        err_spurious;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_SRC   (3),
        .ACC_DEPTH (4),
        .CNT_W     (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .flush_id        (flush_id),
        .rs_id           (rs_id),
        .rs_used_id      (rs_used_id),
        .rd_id           (rd_id),
        .reg_write_id    (reg_write_id),
        .is_acc_id       (is_acc_id),
        .rs_ex           (rs_ex),
        .rd_ex           (rd_ex),
        .mem_read_ex     (mem_read_ex),
        .reg_write_mem   (reg_write_mem),
        .rd_mem          (rd_mem),
        .reg_write_wb    (reg_write_wb),
        .rd_wb           (rd_wb),
        .acc_wb_valid    (acc_wb_valid),
        .acc_wb_rd       (acc_wb_rd),
        .fwd_sel_ex      (fwd_sel_ex),
        .stall_id        (stall_id),
        .acc_pending     (acc_pending),
        .acc_outstanding (acc_outstanding),
        .err_spurious    (err_spurious)
    );

    task automatic idle_inputs();
        id_valid = 0; flush_id = 0; rs_id = '0; rs_used_id = '0; rd_id = '0;
        reg_write_id = 0; is_acc_id = 0; rs_ex = '0; rd_ex = '0; mem_read_ex = 0;
        reg_write_mem = 0; rd_mem = '0; reg_write_wb = 0; rd_wb = '0;
        acc_wb_valid = 0; acc_wb_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_op(input logic [4:0] rd);
        id_valid = 1; is_acc_id = 1; reg_write_id = 1; rd_id = rd; rs_used_id = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        n_cmp++; if (acc_pending !== 32'h0) begin n_bad++; $display("FAIL reset_pending got=%h exp=%h", acc_pending, 32'h0); end
        n_cmp++; if (acc_outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", acc_outstanding); end
        n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
        n_cmp++; if (fwd_sel_ex !== 6'b0) begin n_bad++; $display("FAIL reset_fwd got=%b exp=000000", fwd_sel_ex); end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        reg_write_mem = 1; rd_mem = 5; reg_write_wb = 1; rd_wb = 5;
        rs_ex = {5'd0, 5'd0, 5'd5};
        #1;
        n_cmp++; if (fwd_sel_ex[1:0] !== 2'b10) begin n_bad++; $display("FAIL fwd_mem_over_wb got=%b exp=10", fwd_sel_ex[1:0]); end
        reg_write_mem = 0; rs_ex = {5'd0, 5'd5, 5'd0};
        #1;
        n_cmp++; if (fwd_sel_ex !== 6'b000100) begin n_bad++; $display("FAIL fwd_wb_op1 got=%b exp=000100", fwd_sel_ex); end
        reg_write_mem = 1; rd_mem = 0; rd_wb = 0; rs_ex = '0;
        #1;
        n_cmp++; if (fwd_sel_ex !== 6'b0) begin n_bad++; $display("FAIL fwd_x0 got=%b exp=000000", fwd_sel_ex); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        mem_read_ex = 1; rd_ex = 7; id_valid = 1;
        rs_id = {5'd0, 5'd7, 5'd3}; rs_used_id = 3'b010;
        #1;
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL load_use_stall got=%b exp=1", stall_id); end
        rs_used_id = 3'b001;
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL load_use_unused got=%b exp=0", stall_id); end
    endtask

    task automatic test_acc_raw_waw();
        idle_inputs();
        acc_op(9);
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL acc9_issue_stall got=%b exp=0", stall_id); end
        step();
        n_cmp++; if (acc_pending !== 32'h0000_0200) begin n_bad++; $display("FAIL acc9_pending got=%h exp=00000200", acc_pending); end
        n_cmp++; if (acc_outstanding !== 3'd1) begin n_bad++; $display("FAIL acc9_count got=%0d exp=1", acc_outstanding); end
        idle_inputs();
        id_valid = 1; rs_id = {5'd0, 5'd0, 5'd9}; rs_used_id = 3'b001;
        #1;
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL raw9_stall got=%b exp=1", stall_id); end
        step();
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL raw9_stall_hold got=%b exp=1", stall_id); end
        rs_used_id = '0; reg_write_id = 1; rd_id = 9;
        #1;
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL waw9_stall got=%b exp=1", stall_id); end
        reg_write_id = 0; rs_used_id = 3'b001;
        acc_wb_valid = 1; acc_wb_rd = 9; rs_ex = {5'd0, 5'd0, 5'd9};
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL raw9_release got=%b exp=0", stall_id); end
        n_cmp++; if (fwd_sel_ex[1:0] !== 2'b11) begin n_bad++; $display("FAIL fwd_acc got=%b exp=11", fwd_sel_ex[1:0]); end
        n_cmp++; if (acc_pending[9] !== 1'b1) begin n_bad++; $display("FAIL acc9_still_pending got=%b exp=1", acc_pending[9]); end
        step();
        idle_inputs();
        #1;
        n_cmp++; if (acc_pending !== 32'h0) begin n_bad++; $display("FAIL acc9_cleared got=%h exp=00000000", acc_pending); end
        n_cmp++; if (acc_outstanding !== 3'd0) begin n_bad++; $display("FAIL acc9_count_zero got=%0d exp=0", acc_outstanding); end
        n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL acc9_no_err got=%b exp=0", err_spurious); end
    endtask

    task automatic test_full_queue();
        idle_inputs();
        for (int r = 1; r <= 4; r++) begin
            acc_op(5'(r));
            step();
        end
        n_cmp++; if (acc_outstanding !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", acc_outstanding); end
        n_cmp++; if (acc_pending !== 32'h0000_001E) begin n_bad++; $display("FAIL full_pending got=%h exp=0000001e", acc_pending); end
        acc_op(5);
        #1;
        n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL full_stall got=%b exp=1", stall_id); end
        acc_wb_valid = 1; acc_wb_rd = 2;
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL full_release got=%b exp=0", stall_id); end
        step();
        idle_inputs();
        #1;
        n_cmp++; if (acc_outstanding !== 3'd4) begin n_bad++; $display("FAIL full_swap_count got=%0d exp=4", acc_outstanding); end
        n_cmp++; if (acc_pending !== 32'h0000_003A) begin n_bad++; $display("FAIL full_swap_pending got=%h exp=0000003a", acc_pending); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        acc_op(3);
        acc_wb_valid = 1; acc_wb_rd = 3;
        #1;
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL reissue3_stall got=%b exp=0", stall_id); end
        step();
        idle_inputs();
        #1;
        n_cmp++; if (acc_pending !== 32'h0000_003A) begin n_bad++; $display("FAIL reissue3_pending got=%h exp=0000003a", acc_pending); end
        n_cmp++; if (acc_outstanding !== 3'd4) begin n_bad++; $display("FAIL reissue3_count got=%0d exp=4", acc_outstanding); end
        n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL reissue3_err got=%b exp=0", err_spurious); end
        acc_wb_valid = 1; acc_wb_rd = 12;
        step();
        idle_inputs();
        #1;
        n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL spurious_set got=%b exp=1", err_spurious); end
        n_cmp++; if (acc_outstanding !== 3'd4) begin n_bad++; $display("FAIL spurious_count got=%0d exp=4", acc_outstanding); end
        step();
        n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL spurious_sticky got=%b exp=1", err_spurious); end
        acc_wb_valid = 1; acc_wb_rd = 1;
        step();
        idle_inputs();
        #1;
        n_cmp++; if (acc_outstanding !== 3'd3) begin n_bad++; $display("FAIL complete1_count got=%0d exp=3", acc_outstanding); end
    endtask

    task automatic test_mid_reset_flush();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        id_valid = 1; rs_id = {5'd0, 5'd4, 5'd3}; rs_used_id = 3'b011;
        #1;
        n_cmp++; if (acc_pending !== 32'h0) begin n_bad++; $display("FAIL midrst_pending got=%h exp=00000000", acc_pending); end
        n_cmp++; if (acc_outstanding !== 3'd0) begin n_bad++; $display("FAIL midrst_count got=%0d exp=0", acc_outstanding); end
        n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b exp=0", err_spurious); end
        n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL midrst_stall got=%b exp=0", stall_id); end
        idle_inputs();
        acc_op(20);
        flush_id = 1;
        step();
        idle_inputs();
        #1;
        n_cmp++; if (acc_pending !== 32'h0) begin n_bad++; $display("FAIL flush_pending got=%h exp=00000000", acc_pending); end
        n_cmp++; if (acc_outstanding !== 3'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", acc_outstanding); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_acc_raw_waw();
        test_full_queue();
        test_back_to_back();
        test_mid_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
